// File: rtl/hazard_unit.sv
// Pipeline hazard detection: stalls on RAW matches, redirects/flushes on taken branches; HAZARD_FORWARD_EN enables EX operand forwarding.
// Latency: outputs are combinational from inputs and the RUN/STALL state, so a detected hazard stalls in the same cycle.
// Backpressure: data_hazard holds PC and IF/ID for the full stall length; a taken branch overrides any stall.
module hazard_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic [4:0] mem_rd,
    input  logic [4:0] wb_rd,
    input  logic       ex_we,
    input  logic       mem_we,
    input  logic       wb_we,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic       ex_branch_taken,
    output logic       data_hazard,
    output logic       control_hazard,
    output logic       flush_ifid,
    output logic       flush_idex,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    logic [0:0] state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [1:0] need;
    logic       ex_hit, mem_hit, wb_hit;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // x0 is hardwired to zero, so it never participates in a match.
    function automatic logic hit(input logic [4:0] src, input logic used,
                                 input logic [4:0] dst, input logic we);
        return we && used && (dst != 5'd0) && (src == dst);
    endfunction

    assign ex_hit  = hit(id_rs1, id_rs1_used, ex_rd, ex_we)
                   | hit(id_rs2, id_rs2_used, ex_rd, ex_we);
    assign mem_hit = hit(id_rs1, id_rs1_used, mem_rd, mem_we)
                   | hit(id_rs2, id_rs2_used, mem_rd, mem_we);
    assign wb_hit  = hit(id_rs1, id_rs1_used, wb_rd, wb_we)
                   | hit(id_rs2, id_rs2_used, wb_rd, wb_we);

`ifdef HAZARD_FORWARD_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (hit(src, 1'b1, mem_rd, mem_we))
            return 2'b01;
        else if (hit(src, 1'b1, wb_rd, wb_we))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // With forwarding only a load in EX cannot supply its result in time.
    assign need      = (ex_hit && ex_is_load) ? 2'd1 : 2'd0;
    assign fwd_a_raw = fwd_sel(ex_rs1);
    assign fwd_b_raw = fwd_sel(ex_rs2);

    logic unused_fwd_on;
    assign unused_fwd_on = mem_hit ^ wb_hit;
`else
    // Nearest writer dominates: it needs the longest wait.
    always_comb begin
        need = 2'd0;
        if (ex_hit)
            need = 2'd3;
        else if (mem_hit)
            need = 2'd2;
        else if (wb_hit)
            need = 2'd1;
    end

    assign fwd_a_raw = 2'b00;
    assign fwd_b_raw = 2'b00;

    logic unused_fwd_off;
    assign unused_fwd_off = ^{ex_is_load, ex_rs1, ex_rs2};
`endif

    always_comb begin
        data_hazard    = 1'b0;
        control_hazard = 1'b0;
        flush_ifid     = 1'b0;
        flush_idex     = 1'b0;
        fwd_a          = 2'b00;
        fwd_b          = 2'b00;
        if (!rst) begin
            fwd_a = fwd_a_raw;
            fwd_b = fwd_b_raw;
            if (ex_branch_taken) begin
                control_hazard = 1'b1;
                flush_ifid     = 1'b1;
                flush_idex     = 1'b1;
            end else if (state == STALL || need != 2'd0) begin
                data_hazard = 1'b1;
                flush_idex  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ex_branch_taken) begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
        end else if (state == STALL) begin
            cnt_nxt = cnt - 2'd1;
            if (cnt == 2'd1)
                state_nxt = RUN;
        end else if (need > 2'd1) begin
            state_nxt = STALL;
            cnt_nxt   = need - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: expected output vectors are queued with each stimulus cycle and popped at the sampling edge.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
    logic       id_rs1_used, id_rs2_used, ex_we, mem_we, wb_we, ex_is_load, ex_branch_taken;
    logic       data_hazard, control_hazard, flush_ifid, flush_idex;
    logic [1:0] fwd_a, fwd_b;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
        .ex_is_load(ex_is_load), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_branch_taken(ex_branch_taken),
        .data_hazard(data_hazard), .control_hazard(control_hazard),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] exrd, memrd, wbrd;
        logic       exwe, memwe, wbwe, load;
        logic [4:0] exrs1, exrs2;
        logic       br;
    } stim_t;

    // {data_hazard, control_hazard, flush_ifid, flush_idex, fwd_a, fwd_b}
    localparam logic [7:0] Z  = 8'b0000_0000;
    localparam logic [7:0] DH = 8'b1001_0000;
    localparam logic [7:0] CH = 8'b0111_0000;

    logic [7:0] exp_q[$];
    logic [7:0] got, want;
    int total = 0;
    int bad   = 0;

    function automatic stim_t idle();
        stim_t t;
        t = '0;
        return t;
    endfunction

    task automatic apply(input stim_t t);
        rst = t.rst; id_rs1 = t.rs1; id_rs2 = t.rs2;
        id_rs1_used = t.u1; id_rs2_used = t.u2;
        ex_rd = t.exrd; mem_rd = t.memrd; wb_rd = t.wbrd;
        ex_we = t.exwe; mem_we = t.memwe; wb_we = t.wbwe;
        ex_is_load = t.load; ex_rs1 = t.exrs1; ex_rs2 = t.exrs2;
        ex_branch_taken = t.br;
    endtask

    function automatic stim_t ex_match(input logic [4:0] r, input logic load);
        stim_t t;
        t = idle(); t.exrd = r; t.exwe = 1'b1; t.load = load; t.rs1 = r; t.u1 = 1'b1;
        return t;
    endfunction

    task automatic test_reset();
        stim_t s[$];
        stim_t t;
        t = ex_match(5'd6, 1'b1); t.rst = 1'b1; t.br = 1'b1;
        t.memrd = 5'd2; t.memwe = 1'b1; t.exrs1 = 5'd2;
        s.push_back(t); exp_q.push_back(Z);
        s.push_back(t); exp_q.push_back(Z);
        s.push_back(idle()); exp_q.push_back(Z);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); @(negedge clk);
            got = {data_hazard, control_hazard, flush_ifid, flush_idex, fwd_a, fwd_b};
            want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL reset[%0d] got=%b want=%b", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_x0();
        stim_t s[$];
        stim_t t;
        t = idle(); t.exrd = 5'd0; t.exwe = 1'b1; t.load = 1'b1; t.rs1 = 5'd0; t.u1 = 1'b1;
        s.push_back(t); exp_q.push_back(Z);
        t.memwe = 1'b1; t.wbwe = 1'b1; t.rs2 = 5'd0; t.u2 = 1'b1;
        s.push_back(t); exp_q.push_back(Z);
        // not used / not writing must also be silent
        t = ex_match(5'd4, 1'b1); t.u1 = 1'b0; s.push_back(t); exp_q.push_back(Z);
        t = ex_match(5'd4, 1'b1); t.exwe = 1'b0; s.push_back(t); exp_q.push_back(Z);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); @(negedge clk);
            got = {data_hazard, control_hazard, flush_ifid, flush_idex, fwd_a, fwd_b};
            want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL x0_unused[%0d] got=%b want=%b", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_with_match();
        stim_t s[$];
        stim_t t;
        t = ex_match(5'd8, 1'b1); t.br = 1'b1;
        s.push_back(t); exp_q.push_back(CH);
        s.push_back(idle()); exp_q.push_back(Z);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); @(negedge clk);
            got = {data_hazard, control_hazard, flush_ifid, flush_idex, fwd_a, fwd_b};
            want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL branch_match[%0d] got=%b want=%b", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

`ifdef HAZARD_FORWARD_EN
    task automatic test_fwd();
        stim_t s[$];
        stim_t t;
        s.push_back(ex_match(5'd5, 1'b1)); exp_q.push_back(DH);
        t = idle(); t.memrd = 5'd5; t.memwe = 1'b1; t.exrs1 = 5'd5;
        s.push_back(t); exp_q.push_back(8'b0000_0100);
        t = idle(); t.memrd = 5'd9; t.memwe = 1'b1; t.wbrd = 5'd9; t.wbwe = 1'b1; t.exrs2 = 5'd9;
        s.push_back(t); exp_q.push_back(8'b0000_0001);
        t = idle(); t.wbrd = 5'd9; t.wbwe = 1'b1; t.exrs1 = 5'd9; t.exrs2 = 5'd9;
        s.push_back(t); exp_q.push_back(8'b0000_1010);
        t = idle(); t.memrd = 5'd0; t.memwe = 1'b1; t.wbrd = 5'd0; t.wbwe = 1'b1;
        s.push_back(t); exp_q.push_back(Z);
        s.push_back(ex_match(5'd4, 1'b0)); exp_q.push_back(Z);
        t = idle(); t.memrd = 5'd3; t.memwe = 1'b1; t.rs2 = 5'd3; t.u2 = 1'b1;
        s.push_back(t); exp_q.push_back(Z);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); @(negedge clk);
            got = {data_hazard, control_hazard, flush_ifid, flush_idex, fwd_a, fwd_b};
            want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL fwd[%0d] got=%b want=%b", i, got, want); end
            @(posedge clk); #1;
        end
    endtask
`else
    task automatic test_ex_stall();
        stim_t s[$];
        stim_t t;
        t = idle(); t.exrd = 5'd7; t.exwe = 1'b1; t.rs2 = 5'd7; t.u2 = 1'b1;
        s.push_back(t); exp_q.push_back(DH);
        t = idle(); t.wbrd = 5'd3; t.wbwe = 1'b1; t.rs1 = 5'd3; t.u1 = 1'b1;
        s.push_back(t); exp_q.push_back(DH);
        s.push_back(idle()); exp_q.push_back(DH);
        s.push_back(idle()); exp_q.push_back(Z);
        s.push_back(idle()); exp_q.push_back(Z);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); @(negedge clk);
            got = {data_hazard, control_hazard, flush_ifid, flush_idex, fwd_a, fwd_b};
            want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL ex_stall[%0d] got=%b want=%b", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wb();
        stim_t s[$];
        stim_t t;
        t = idle(); t.wbrd = 5'd11; t.wbwe = 1'b1; t.rs1 = 5'd11; t.u1 = 1'b1;
        t.memrd = 5'd12; t.memwe = 1'b1; t.rs2 = 5'd12; t.u2 = 1'b1;
        s.push_back(t); exp_q.push_back(DH);
        s.push_back(idle()); exp_q.push_back(DH);
        s.push_back(idle()); exp_q.push_back(Z);
        t = idle(); t.wbrd = 5'd13; t.wbwe = 1'b1; t.rs2 = 5'd13; t.u2 = 1'b1;
        s.push_back(t); exp_q.push_back(DH);
        s.push_back(idle()); exp_q.push_back(Z);
        // forwarding muxes stay on the register file in this build
        t = idle(); t.memrd = 5'd5; t.memwe = 1'b1; t.exrs1 = 5'd5; t.wbrd = 5'd6; t.wbwe = 1'b1; t.exrs2 = 5'd6;
        s.push_back(t); exp_q.push_back(Z);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); @(negedge clk);
            got = {data_hazard, control_hazard, flush_ifid, flush_idex, fwd_a, fwd_b};
            want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL mem_wb[%0d] got=%b want=%b", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_abort();
        stim_t s[$];
        stim_t t;
        s.push_back(ex_match(5'd7, 1'b0)); exp_q.push_back(DH);
        t = idle(); t.br = 1'b1;
        s.push_back(t); exp_q.push_back(CH);
        s.push_back(idle()); exp_q.push_back(Z);
        s.push_back(idle()); exp_q.push_back(Z);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); @(negedge clk);
            got = {data_hazard, control_hazard, flush_ifid, flush_idex, fwd_a, fwd_b};
            want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL branch_abort[%0d] got=%b want=%b", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_reset();
        stim_t s[$];
        stim_t t;
        s.push_back(ex_match(5'd10, 1'b0)); exp_q.push_back(DH);
        t = ex_match(5'd10, 1'b0); t.rst = 1'b1;
        s.push_back(t); exp_q.push_back(Z);
        s.push_back(idle()); exp_q.push_back(Z);
        s.push_back(idle()); exp_q.push_back(Z);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); @(negedge clk);
            got = {data_hazard, control_hazard, flush_ifid, flush_idex, fwd_a, fwd_b};
            want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL stall_reset[%0d] got=%b want=%b", i, got, want); end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        apply(idle());
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_x0();
        test_branch_with_match();
`ifdef HAZARD_FORWARD_EN
        test_fwd();
`else
        test_ex_stall();
        test_mem_wb();
        test_branch_abort();
        test_stall_reset();
`endif
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
